// File: rtl/spcm_spi_master.sv
// Byte-level SPI mode-0 master for the serial phase-change memory.
// It owns SCK generation, chip-select setup/hold/idle timing and held multi-byte transactions.
module spcm_spi_master #(
  parameter int CLK_FREQ = 100,
  parameter int SCK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       keep,
  input  logic       release_req,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       ack,
  output logic       spcm_cs_n,
  output logic       spcm_sck,
  output logic       spcm_mosi,
  input  logic       spcm_miso
);

  if (CLK_FREQ < 1 || SCK_DIV < 1 || CS_SETUP < 1 || CS_HOLD < 1 || CS_IDLE < 1) begin : g_param_check
    $error("spcm_spi_master: all timing parameters must be >= 1");
  end

  localparam logic [15:0] DIV_LAST   = 16'(SCK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HELD, HOLD, GAP} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [4:0]  half_cnt;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic        keep_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      spcm_cs_n <= 1'b1;
      spcm_sck  <= 1'b0;
      spcm_mosi <= 1'b0;
      rx_data   <= 8'h00;
      ack       <= 1'b0;
      busy      <= 1'b0;
      cnt       <= 16'd0;
      half_cnt  <= 5'd0;
      keep_q    <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sh     <= tx_data;
            keep_q    <= keep;
            spcm_mosi <= tx_data[7];
            spcm_cs_n <= 1'b0;
            busy      <= 1'b1;
            cnt       <= 16'd0;
            half_cnt  <= 5'd0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= 16'd0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SHIFT: begin
          // half_cnt counts SCK half-periods; 16 means the 8th falling edge has already happened
          if (half_cnt == 5'd16) begin
            ack     <= 1'b1;
            rx_data <= rx_sh;
            cnt     <= 16'd0;
            if (keep_q) begin
              busy  <= 1'b0;
              state <= HELD;
            end else begin
              state <= HOLD;
            end
          end else if (cnt == DIV_LAST) begin
            cnt      <= 16'd0;
            half_cnt <= half_cnt + 5'd1;
            spcm_sck <= ~spcm_sck;
            if (!spcm_sck) begin
              rx_sh <= {rx_sh[6:0], spcm_miso};
            end else begin
              if (half_cnt != 5'd15) spcm_mosi <= tx_sh[6];
              tx_sh <= {tx_sh[6:0], 1'b0};
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HELD: begin
          // start takes priority over a simultaneous release
          if (start) begin
            tx_sh     <= tx_data;
            keep_q    <= keep;
            spcm_mosi <= tx_data[7];
            busy      <= 1'b1;
            cnt       <= 16'd0;
            half_cnt  <= 5'd0;
            state     <= SHIFT;
          end else if (release_req) begin
            busy  <= 1'b1;
            cnt   <= 16'd0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt       <= 16'd0;
            spcm_cs_n <= 1'b1;
            state     <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (cnt == IDLE_LAST) begin
            cnt   <= 16'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spcm_spi_master.sv
// Directed bench for spcm_spi_master with a mode-0 slave model and SCK/ack/cs_n monitors.
module tb_spcm_spi_master;

  logic       clk = 1'b0;
  logic       rst, start, keep, release_req;
  logic [7:0] tx_data, rx_data;
  logic       busy, ack, cs_n, sck, mosi, miso;

  always #5 clk = ~clk;

  spcm_spi_master #(
    .CLK_FREQ(100), .SCK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .keep(keep), .release_req(release_req),
    .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .ack(ack),
    .spcm_cs_n(cs_n), .spcm_sck(sck), .spcm_mosi(mosi), .spcm_miso(miso)
  );

  // Slave: loads its reply when a start is accepted, shifts on each SCK falling edge.
  logic [7:0] slv_byte = 8'h00;
  logic [7:0] slv_sh   = 8'h00;
  logic [7:0] mosi_cap = 8'h00;
  logic       sck_q = 1'b0, cs_q = 1'b1;
  int         ack_cnt = 0, rise_cnt = 0, cs_rise_cnt = 0;

  assign miso = slv_sh[7];

  always @(posedge clk) begin
    sck_q <= sck;
    cs_q  <= cs_n;
    if (start && !busy) slv_sh <= slv_byte;
    else if (sck_q && !sck) slv_sh <= {slv_sh[6:0], 1'b0};
    if (!sck_q && sck) begin
      mosi_cap <= {mosi_cap[6:0], mosi};
      rise_cnt <= rise_cnt + 1;
    end
    if (ack) ack_cnt <= ack_cnt + 1;
    if (!cs_q && cs_n) cs_rise_cnt <= cs_rise_cnt + 1;
  end

  int checks = 0, failures = 0;
  int n, a0, r0, c0;
  logic [7:0] bb [4] = '{8'h03, 8'h12, 8'h34, 8'h56};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = ack high, 1 = cs_n high, 2 = busy low; n = cycles taken, -1 on timeout
  task automatic wait_for(input int which, input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if ((which == 0 && ack) || (which == 1 && cs_n) || (which == 2 && !busy)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input logic k, input logic [7:0] s, input logic rel);
    tx_data = b; keep = k; slv_byte = s; release_req = rel; start = 1'b1;
    step();
    start = 1'b0; release_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; keep = 1'b0; release_req = 1'b0; tx_data = 8'h00;
    repeat (3) step();
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sck", sck, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_rx", rx_data, 8'h00);
    chk("rst_ack", ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    step();

    // single byte
    send(8'hA5, 1'b0, 8'h3C, 1'b0);
    chk("s_cs_low", cs_n, 1'b0);
    chk("s_mosi_b7", mosi, 1'b1);
    chk("s_busy", busy, 1'b1);
    wait_for(0, 100, n);
    chk("s_ack_lat", n, 35);
    chk("s_rx", rx_data, 8'h3C);
    chk("s_mosi_bits", mosi_cap, 8'hA5);
    wait_for(1, 20, n);
    chk("s_cs_hold", n, 2);
    wait_for(2, 20, n);
    chk("s_gap", n, 4);
    chk("s_ack_cnt", ack_cnt, 1);

    // burst with cs_n held low
    c0 = cs_rise_cnt;
    send(bb[0], 1'b1, 8'h00, 1'b0);
    wait_for(0, 100, n);
    chk("b0_lat", n, 35);
    chk("b0_held_busy", busy, 1'b0);
    chk("b0_mosi", mosi_cap, bb[0]);
    for (int i = 1; i < 4; i++) begin
      send(bb[i], (i < 3), (i == 3) ? 8'hDE : 8'h00, 1'b0);
      wait_for(0, 100, n);
      chk($sformatf("b%0d_lat", i), n, 33);
      chk($sformatf("b%0d_mosi", i), mosi_cap, bb[i]);
    end
    chk("b_rx_final", rx_data, 8'hDE);
    chk("b_cs_low", cs_rise_cnt, c0);
    wait_for(2, 50, n);
    chk("b_ack_cnt", ack_cnt, 5);

    // HELD then release
    send(8'h9F, 1'b1, 8'h00, 1'b0);
    wait_for(0, 100, n);
    chk("r_ack_lat", n, 35);
    r0 = rise_cnt; c0 = cs_rise_cnt;
    repeat (10) step();
    chk("r_held_cs", cs_n, 1'b0);
    chk("r_held_cs_edges", cs_rise_cnt, c0);
    release_req = 1'b1;
    step();
    release_req = 1'b0;
    chk("r_hold_busy", busy, 1'b1);
    wait_for(1, 20, n);
    chk("r_cs_rel", n, 2);
    chk("r_no_sck", rise_cnt, r0);
    wait_for(2, 20, n);

    // start mid-SHIFT ignored, start in GAP ignored
    a0 = ack_cnt;
    send(8'h11, 1'b0, 8'h00, 1'b0);
    repeat (10) step();
    tx_data = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    wait_for(0, 100, n);
    chk("c_mid_data", mosi_cap, 8'h11);
    wait_for(1, 20, n);
    tx_data = 8'h77; start = 1'b1;
    step();
    start = 1'b0;
    wait_for(2, 20, n);
    repeat (5) step();
    chk("c_gap_busy", busy, 1'b0);
    chk("c_gap_cs", cs_n, 1'b1);
    chk("c_ack_cnt", ack_cnt, a0 + 1);

    // start and release together in HELD
    send(8'h55, 1'b1, 8'h00, 1'b0);
    wait_for(0, 100, n);
    send(8'h66, 1'b0, 8'h00, 1'b1);
    chk("c_sr_busy", busy, 1'b1);
    wait_for(0, 100, n);
    chk("c_sr_lat", n, 33);
    chk("c_sr_mosi", mosi_cap, 8'h66);
    wait_for(2, 50, n);

    // reset after 3 SCK pulses
    a0 = ack_cnt; r0 = rise_cnt;
    send(8'hE7, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (rise_cnt == r0 + 3) break;
      step();
    end
    chk("x_three_pulses", rise_cnt, r0 + 3);
    rst = 1'b1;
    step();
    chk("x_cs_n", cs_n, 1'b1);
    chk("x_sck", sck, 1'b0);
    chk("x_mosi", mosi, 1'b0);
    chk("x_busy", busy, 1'b0);
    chk("x_ack", ack, 1'b0);
    rst = 1'b0;
    step();
    send(8'h5A, 1'b0, 8'h81, 1'b0);
    wait_for(0, 100, n);
    chk("x_new_lat", n, 35);
    chk("x_new_rx", rx_data, 8'h81);
    chk("x_new_mosi", mosi_cap, 8'h5A);
    wait_for(2, 50, n);
    chk("x_ack_cnt", ack_cnt, a0 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
